// File: rtl/sequence_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : sequence_serializer_if
// Brief    : Frame-input handshake and serial-output bundle for the serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface sequence_serializer_if #(
   parameter int FRAME_W = 4
);
   logic [FRAME_W-1:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic               A;
   logic               a_valid;
   logic               frame_start;
   logic [7:0]         match_cnt;
   logic               busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, A, a_valid, frame_start, match_cnt, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, A, a_valid, frame_start, match_cnt, busy
   );
endinterface
`default_nettype wire

// File: rtl/sequence_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sequence_serializer
// Brief    : FIFO-buffered frame serializer, MSB first, gapless back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_serializer #(
   parameter int                 FRAME_W   = 4,
   parameter int                 DEPTH     = 4,
   parameter logic [FRAME_W-1:0] MATCH_PAT = 4'b1101
) (
   input wire logic             clk,
   input wire logic             reset,
   sequence_serializer_if.slave bus
);
   localparam int              AW         = $clog2(DEPTH);
   localparam int              BW         = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam logic [AW:0]     c_DEPTH    = (AW+1)'(DEPTH);
   localparam logic [BW-1:0]   c_LAST_BIT = BW'(FRAME_W-1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [FRAME_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic [FRAME_W-1:0] r_shift;
   logic [BW-1:0]      r_bit_idx;
   logic               r_a;
   logic               r_a_valid;
   logic               r_frame_start;
   logic [7:0]         r_match_cnt;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic               w_last_bit;
   logic [FRAME_W-1:0] w_head;

   assign w_empty      = (r_count == '0);
   assign bus.in_ready = (r_count < c_DEPTH);
   assign w_push       = bus.in_valid && bus.in_ready;
   assign w_head       = r_mem[r_rd_ptr];
   assign w_last_bit   = (r_bit_idx == c_LAST_BIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last_bit) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Storage is never read before being written, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The MSB goes straight to A on the pop edge; r_shift holds the remainder.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_a           <= 1'b0;
         r_a_valid     <= 1'b0;
         r_frame_start <= 1'b0;
         r_match_cnt   <= '0;
      end else begin
         if (w_pop) begin
            r_shift       <= w_head << 1;
            r_a           <= w_head[FRAME_W-1];
            r_a_valid     <= 1'b1;
            r_frame_start <= 1'b1;
            r_bit_idx     <= '0;
         end else if ((r_state == S_SHIFT) && !w_last_bit) begin
            r_shift       <= r_shift << 1;
            r_a           <= r_shift[FRAME_W-1];
            r_a_valid     <= 1'b1;
            r_frame_start <= 1'b0;
            r_bit_idx     <= r_bit_idx + 1'b1;
         end else begin
            r_a           <= 1'b0;
            r_a_valid     <= 1'b0;
            r_frame_start <= 1'b0;
         end
         if (w_pop && (w_head == MATCH_PAT) && (r_match_cnt != 8'hFF)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
         end
      end
   end

   assign bus.A           = r_a;
   assign bus.a_valid     = r_a_valid;
   assign bus.frame_start = r_frame_start;
   assign bus.match_cnt   = r_match_cnt;
   assign bus.busy        = (r_state == S_SHIFT) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sequence_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_serializer
// Brief    : Scoreboard bench for sequence_serializer with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_serializer;
   localparam int FRAME_W = 4;
   localparam int DEPTH   = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   sequence_serializer_if #(.FRAME_W(FRAME_W)) bus ();

   sequence_serializer #(
      .FRAME_W   (FRAME_W),
      .DEPTH     (DEPTH),
      .MATCH_PAT (4'b1101)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic bit_v;
      logic start;
   } exp_t;

   int         n_tests  = 0;
   int         n_fail   = 0;
   exp_t       exp_q[$];
   logic [3:0] m_fifo[$];
   int         m_idx    = -1;
   logic [7:0] m_match  = 8'd0;
   int         m_pushes = 0;
   logic       saw_full = 1'b0;
   int         run_len  = 0;
   int         max_run  = 0;
   logic [3:0] det_sr   = 4'd0;
   int         det_n    = 0;
   int         z_cnt    = 0;
   int         z_pos [2];
   int         bit_idx  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference model: FIFO of frames plus bit index of the frame on A.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_fifo.delete();
         exp_q.delete();
         m_idx   = -1;
         m_match = 8'd0;
      end else begin
         logic       do_push;
         logic       do_pop;
         logic [3:0] f;
         do_push = bus.in_valid && (m_fifo.size() < DEPTH);
         do_pop  = (m_fifo.size() > 0) && ((m_idx < 0) || (m_idx == FRAME_W-1));
         if (do_pop) begin
            f = m_fifo.pop_front();
            if ((f == 4'b1101) && (m_match != 8'hFF)) m_match++;
            m_idx = 0;
         end else if ((m_idx >= 0) && (m_idx < FRAME_W-1)) begin
            m_idx++;
         end else begin
            m_idx = -1;
         end
         if (do_push) begin
            m_fifo.push_back(bus.in_data);
            m_pushes++;
            for (int b = FRAME_W-1; b >= 0; b--)
               exp_q.push_back(exp_t'{bit_v: bus.in_data[b], start: (b == FRAME_W-1)});
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         exp_t e;
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (m_fifo.size() < DEPTH)});
         chk("busy", {31'd0, bus.busy}, {31'd0, ((m_idx >= 0) || (m_fifo.size() > 0))});
         chk("a_valid", {31'd0, bus.a_valid}, {31'd0, (m_idx >= 0)});
         if (bus.in_ready === 1'b0) saw_full = 1'b1;
         if (bus.a_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            chk("bit_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("A", {31'd0, bus.A}, {31'd0, e.bit_v});
               chk("frame_start", {31'd0, bus.frame_start}, {31'd0, e.start});
            end
            det_sr = {det_sr[2:0], bus.A};
            det_n++;
            if ((det_n >= 4) && (det_sr == 4'b1101)) begin
               if (z_cnt < 2) z_pos[z_cnt] = bit_idx;
               z_cnt++;
               det_n = 0;
            end
            bit_idx++;
         end else begin
            run_len = 0;
            chk("A_idle", {31'd0, bus.A}, 32'd0);
            chk("frame_start_idle", {31'd0, bus.frame_start}, 32'd0);
         end
      end
   end

   task automatic push_frame(input logic [3:0] d);
      int start = m_pushes;
      int k     = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while ((m_pushes == start) && (k < 50)) begin
         @(posedge clk); #1;
         k++;
      end
      chk("push_accepted", m_pushes - start, 32'd1);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (((bus.busy !== 1'b0) || (bus.a_valid !== 1'b0)) && (k < 3000)) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_in_time", {31'd0, (k < 3000)}, 32'd1);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_A"}, {31'd0, bus.A}, 32'd0);
      chk({tag, "_a_valid"}, {31'd0, bus.a_valid}, 32'd0);
      chk({tag, "_frame_start"}, {31'd0, bus.frame_start}, 32'd0);
      chk({tag, "_match_cnt"}, {24'd0, bus.match_cnt}, 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   // Called at posedge+#1; reset is asserted between edges.
   task automatic do_reset(input string tag);
      bus.in_valid = 1'b0;
      #1 reset = 1'b0;
      #1 check_reset_state(tag);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0] pat;
      logic [3:0] frames [6];
      int         start;
      int         k;

      bus.in_valid = 1'b0;
      bus.in_data  = 4'd0;
      #1 check_reset_state("por");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single frame: latency, bit order, framing.
      pat = 4'b1101;
      push_frame(pat);
      bus.in_valid = 1'b0;
      chk("lat_k_avalid", {31'd0, bus.a_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("single_A", {31'd0, bus.A}, {31'd0, pat[3-i]});
         chk("single_avalid", {31'd0, bus.a_valid}, 32'd1);
         chk("single_fstart", {31'd0, bus.frame_start}, {31'd0, (i == 0)});
      end
      @(posedge clk); #1;
      chk("single_idle_after", {31'd0, bus.a_valid}, 32'd0);
      chk("single_match", {24'd0, bus.match_cnt}, 32'd1);

      // Six frames with in_valid held: FIFO fills, output is gapless.
      do_reset("rst_a");
      frames = '{4'b1010, 4'b0110, 4'b1101, 4'b0001, 4'b1111, 4'b0011};
      saw_full = 1'b0;
      max_run  = 0;
      foreach (frames[i]) push_frame(frames[i]);
      bus.in_valid = 1'b0;
      wait_drain();
      chk("burst_saw_full", {31'd0, saw_full}, 32'd1);
      chk("burst_contiguous", max_run, 32'd24);
      chk("burst_match", {24'd0, bus.match_cnt}, 32'd1);

      // Reset mid-frame with two frames queued.
      do_reset("rst_b");
      push_frame(4'b1101);
      push_frame(4'b0110);
      push_frame(4'b1010);
      chk("mid_second_bit", {31'd0, bus.A}, 32'd1);
      do_reset("rst_mid");
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("post_rst_quiet", {31'd0, bus.a_valid}, 32'd0);
      end

      // Saturation of the match counter.
      do_reset("rst_c");
      start        = m_pushes;
      k            = 0;
      bus.in_data  = 4'b1101;
      bus.in_valid = 1'b1;
      while (((m_pushes - start) < 260) && (k < 5000)) begin
         @(posedge clk); #1;
         k++;
         if ((m_pushes - start) == 260) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("sat_pushes", m_pushes - start, 32'd260);
      wait_drain();
      chk("sat_match", {24'd0, bus.match_cnt}, 32'd255);
      chk("sat_model", {24'd0, bus.match_cnt}, {24'd0, m_match});

      // Downstream non-overlapping detector stays frame-aligned.
      do_reset("rst_d");
      det_sr  = 4'd0;
      det_n   = 0;
      z_cnt   = 0;
      bit_idx = 0;
      z_pos   = '{-1, -1};
      push_frame(4'b1101);
      push_frame(4'b0000);
      push_frame(4'b1101);
      bus.in_valid = 1'b0;
      wait_drain();
      chk("det_bits", bit_idx, 32'd12);
      chk("det_z_count", z_cnt, 32'd2);
      chk("det_z_first", z_pos[0], 32'd3);
      chk("det_z_second", z_pos[1], 32'd11);
      chk("det_match", {24'd0, bus.match_cnt}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sequence_serializer.md
SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

Interface
REQ-001 Parameter FRAME_W, default 4: bits per serial frame.
REQ-002 Parameter DEPTH, default 4: input FIFO depth in frames, power of two, at least 2.
REQ-003 Parameter MATCH_PAT, default 4'b1101: frame value counted by match_cnt.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_data  input  FRAME_W  frame to transmit; MSB is sent first.
REQ-007 in_valid  input  1  in_data holds a frame offered for transfer.
REQ-008 in_ready  output  1  FIFO can accept a frame this cycle.
REQ-009 A  output  1  serial bit stream, one bit per clock.
REQ-010 a_valid  output  1  A carries a frame bit this cycle.
REQ-011 frame_start  output  1  A carries the first (MSB) bit of a frame.
REQ-012 match_cnt  output  8  count of transmitted frames equal to MATCH_PAT.
REQ-013 busy  output  1  state is SHIFT or the FIFO is non-empty.

Function
REQ-014 A frame SHALL transfer into the FIFO on a rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be combinational: 1 when the FIFO count is less than DEPTH, otherwise 0.
  - A pop on the same edge SHALL NOT enable a push while the FIFO is full.
REQ-016 The FIFO SHALL preserve order; pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-017 The FSM SHALL have exactly two states:
  - IDLE: a_valid=0, A=0.
  - SHIFT: emitting bits from the frame shift register.
REQ-018 In IDLE with the FIFO non-empty, the next edge SHALL:
  - pop the head frame into the shift register;
  - drive A=frame MSB, a_valid=1, frame_start=1;
  - enter SHIFT.
REQ-019 In SHIFT, each edge SHALL advance one bit, MSB to LSB, so a frame occupies exactly FRAME_W consecutive cycles.
REQ-020 On the edge leaving the LSB cycle:
  - FIFO non-empty: SHALL pop and start the next frame with no idle gap (frame_start=1 again).
  - FIFO empty: SHALL return to IDLE.
REQ-021 A, a_valid and frame_start SHALL be registered outputs; frame_start SHALL be 1 only in a frame's first bit cycle.
REQ-022 Latency: a frame pushed into an empty FIFO at edge k with the FSM in IDLE SHALL have its MSB on A after edge k+1 and its LSB after edge k+FRAME_W.
REQ-023 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-024 match_cnt SHALL increment on the edge that pops a frame equal to MATCH_PAT and SHALL saturate at 255.
REQ-025 Frames SHALL be sent whole and non-overlapping, so a downstream non-overlapping FRAME_W-bit detector fed back-to-back frames stays frame-aligned.
REQ-026 in_valid while in_ready=0 SHALL have no effect; in_data is not sampled.

Reset
REQ-027 While reset=0, the block SHALL immediately and asynchronously force:
  - A=0, a_valid=0, frame_start=0;
  - match_cnt=0, busy=0;
  - FIFO empty (in_ready=1), FSM in IDLE.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and all queued frames.
  - No remaining bits SHALL be emitted after release.
REQ-029 After reset releases, the first edge with FIFO data SHALL behave per REQ-018.

Verification
REQ-030 Assert reset=0 asynchronously between edges -> all outputs immediately at their REQ-027 values.
REQ-031 Push single 4'b1101 at edge k -> A=1,1,0,1 after edges k+1..k+4; a_valid=1 for those 4 cycles; frame_start=1 only after k+1; idle afterwards; match_cnt=1.
REQ-032 Push 4'b1010,4'b0110,4'b1101,4'b0001,4'b1111,4'b0011 with in_valid held high -> in_ready=0 while FIFO holds 4 frames; all 6 frames emitted in order as 24 contiguous a_valid cycles; match_cnt=1.
REQ-033 Pulse reset low after the 2nd bit of 4'b1101 with 2 frames queued -> outputs cleared; a_valid stays 0 after release until a new push.
REQ-034 Push 260 frames of 4'b1101 -> match_cnt reads 255 at the end, not wrapping.
REQ-035 Drive A into the team's sequencemachine detector; stream 1101,0000,1101 back-to-back -> detector Z pulses exactly twice, on the final-bit cycles of frames 1 and 3; match_cnt=2.
